// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared fetch-unit state encoding, instruction defaults and opcode helper
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  localparam int INSTR_W_DEF = 32;
  localparam logic [5:0] HALT_OP_DEF = 6'b111111;
  function automatic logic [5:0] opcode(input logic [INSTR_W_DEF-1:0] instr);
    return instr[31:26];
  endfunction
endpackage

// File: rtl/instr_fetch_unit_instr_mem.sv
// instr_mem: combinational-read instruction store whose contents come from the INIT image
module instr_mem #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 32,
  parameter logic [INSTR_W*(2**PC_W)-1:0] INIT = '0
) (
  input  logic [PC_W-1:0]    addr,
  output logic [INSTR_W-1:0] data
);
  assign data = INIT[addr*INSTR_W +: INSTR_W];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-slot instruction fetch with stall, redirect flush and halt detection
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [5:0] HALT_OP = HALT_OP_DEF,
  parameter logic [INSTR_W*(2**PC_W)-1:0] IMEM_INIT = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               halted
);
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n, out_pc_n;
  logic [INSTR_W-1:0] imem_data, out_instr_n;
  logic out_valid_n;
  instr_mem #(.PC_W(PC_W), .INSTR_W(INSTR_W), .INIT(IMEM_INIT)) u_imem (
    .addr(pc),
    .data(imem_data)
  );
  assign halted = state == HALT;
  // a registered halt instruction blocks further fetches until it is accepted or flushed
  always_comb begin
    state_n = state;
    pc_n = pc;
    out_valid_n = out_valid;
    out_instr_n = out_instr;
    out_pc_n = out_pc;
    if (state == IDLE && start) begin
      state_n = FETCH;
      pc_n = '0;
    end else if (state == FETCH) begin
      if (redirect_valid) begin
        out_valid_n = 1'b0;
        pc_n = redirect_pc;
      end else if (out_valid && opcode(out_instr) == HALT_OP) begin
        state_n = out_ready ? HALT : FETCH;
        out_valid_n = !out_ready;
      end else if (!out_valid || out_ready) begin
        out_valid_n = 1'b1;
        out_instr_n = imem_data;
        out_pc_n = pc;
        pc_n = pc + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      out_valid <= out_valid_n;
      out_instr <= out_instr_n;
      out_pc <= out_pc_n;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit against a behavioural model
module tb_instr_fetch_unit;
  localparam logic [5:0] HOP = 6'h3f;
  function automatic logic [31:0] img_word(input logic [7:0] a);
    if (a == 8'd2 || a == 8'd120) return {HOP, 2'b00, a, 16'h0};
    return {2'b00, a[3:0], 2'b01, a, 8'(a * 7 + 3), a ^ 8'h5a};
  endfunction
  function automatic logic [8191:0] build_img();
    logic [8191:0] v;
    v = '0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++)
        v[(4 * i + j) * 32 +: 32] = img_word(8'(4 * i + j));
    return v;
  endfunction
  localparam logic [8191:0] IMG = build_img();
  logic clk = 0, rst = 1, start = 0, redirect_valid = 0, out_ready = 0;
  logic [7:0] redirect_pc = '0;
  logic out_valid, halted;
  logic [31:0] out_instr;
  logic [7:0] out_pc;
  int n_cmp = 0, n_bad = 0;
  bit m_run, m_halt, m_val;
  logic [7:0] m_pc, m_opc;
  logic [31:0] m_ins;
  instr_fetch_unit #(.PC_W(8), .INSTR_W(32), .HALT_OP(HOP), .IMEM_INIT(IMG)) dut (
    .clk(clk), .rst(rst), .start(start), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_ready(out_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step();
    if (!m_run && !m_halt) begin
      if (start) begin m_run = 1; m_pc = 0; end
    end else if (m_run) begin
      if (redirect_valid) begin
        m_val = 0;
        m_pc = redirect_pc;
      end else if (m_val && m_ins[31:26] == HOP) begin
        if (out_ready) begin m_run = 0; m_halt = 1; m_val = 0; end
      end else if (!m_val || out_ready) begin
        m_val = 1;
        m_ins = img_word(m_pc);
        m_opc = m_pc;
        m_pc = m_pc + 8'd1;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("valid", out_valid, m_val);
    chk("halted", halted, m_halt);
    if (m_val) begin
      chk("out_pc", out_pc, m_opc);
      chk("out_instr", out_instr, m_ins);
    end
  endtask
  task automatic do_reset();
    #2 rst = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_halted", halted, 0);
    m_run = 0; m_halt = 0; m_val = 0; m_pc = 0; m_opc = 0; m_ins = 0;
    @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic go();
    start = 1;
    cyc();
    start = 0;
    cyc();
  endtask
  initial begin
    do_reset();
    out_ready = 1;
    go();
    chk("s1_pc0", out_pc, 0);
    cyc(); chk("s1_pc1", out_pc, 1);
    cyc(); chk("s1_pc2", out_pc, 2);
    chk("s1_halt_op", out_instr[31:26], HOP);
    cyc(); chk("s1_halted", halted, 1); chk("s1_idle_valid", out_valid, 0);
    start = 1; redirect_valid = 1; redirect_pc = 8'd7;
    cyc(); cyc();
    start = 0; redirect_valid = 0;
    chk("s1_stay_halted", halted, 1); chk("s1_stay_invalid", out_valid, 0);
    do_reset();
    go();
    cyc(); chk("s2_pc1", out_pc, 1);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("s2_hold_pc", out_pc, 1); chk("s2_hold_instr", out_instr, img_word(8'd1));
    end
    out_ready = 1;
    cyc(); chk("s2_pc2", out_pc, 2);
    do_reset();
    go();
    redirect_valid = 1; redirect_pc = 8'd3;
    cyc(); redirect_valid = 0;
    cyc(); cyc(); cyc(); chk("s3_pc5", out_pc, 5);
    redirect_valid = 1; redirect_pc = 8'd40;
    cyc(); redirect_valid = 0; chk("s3_flush", out_valid, 0);
    cyc(); chk("s3_pc40", out_pc, 40); chk("s3_valid40", out_valid, 1);
    redirect_valid = 1; redirect_pc = 8'd255;
    cyc(); redirect_valid = 0;
    cyc(); chk("s4_pc255", out_pc, 255);
    cyc(); chk("s4_wrap0", out_pc, 0);
    cyc(); chk("s4_pc1", out_pc, 1);
    start = 1;
    cyc(); start = 0; chk("s5_pc2_halt", out_pc, 2);
    redirect_valid = 1; redirect_pc = 8'd10;
    cyc(); redirect_valid = 0; chk("s5_not_halted", halted, 0);
    cyc(); chk("s5_pc10", out_pc, 10); chk("s5_still_run", halted, 0);
    out_ready = 0;
    cyc();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("s6_no_fetch", out_valid, 0);
    end
    for (int e = 0; e < 4; e++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        start = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 9) == 0);
        redirect_pc = 8'($urandom_range(0, 255));
        cyc();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
